pipe_stage_regs: RTL and testbench
==================================

// Module: pipe_stage_regs
// PURPOSE
//  Generic parametrised pipeline-stage register for the CPU datapath (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Carries an opaque data word and a control word between stages, with a valid/ready handshake,
//  stall back-pressure, synchronous flush and bubble-safe control clearing.
//  Optional 2-entry skid mode gives full throughput with a registered in_ready that breaks the stall path.
// PARAMETERS
//  DATA_W  64  width of datapath payload (alu result, store data, reg index...)
//  CTRL_W  8   width of control payload (reg/mem write enables, is_jump, mem_to_reg...)
//  SKID    1   1: 2-entry skid buffer, registered in_ready; 0: single register, combinational in_ready
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       synchronous, active-high reset
//  flush      in   1       synchronous discard of all held entries (branch/jump squash)
//  in_valid   in   1       upstream stage presents an entry
//  in_ready   out  1       this stage accepts an entry this cycle
//  in_data    in   DATA_W  upstream payload
//  in_ctrl    in   CTRL_W  upstream control bits
//  out_valid  out  1       entry presented to downstream stage
//  out_ready  in   1       downstream accepts (0 = stall)
//  out_data   out  DATA_W  payload to downstream
//  out_ctrl   out  CTRL_W  control to downstream; forced 0 whenever out_valid=0
//  count      out  2       entries held (0..2 with SKID=1, 0..1 with SKID=0)
// BEHAVIOUR
//  - Push = in_valid & in_ready; pop = out_valid & out_ready; both sampled at posedge clk.
//  - Reset (dominates all): out_valid=0, out_ctrl=0, out_data=0, count=0; in_ready=1 from the cycle after.
//  - Flush (priority below reset, above push/pop): next cycle count=0, out_valid=0, out_ctrl=0,
//    in_ready=1; a push coincident with flush is dropped; out_data keeps its old value.
//  - Latency: empty stage, push at edge N -> out_valid=1 with that entry after edge N.
//  - Ordering strictly FIFO; no entry dropped or duplicated except by flush/reset.
//  - Stability: while out_valid & ~out_ready, out_data/out_ctrl hold unchanged.
//  - Bubble: out_valid=0 => out_ctrl==0 (no stray write enables); out_data holds last value.
//  - SKID=0: one register; in_ready = ~out_valid | out_ready (comb.). Push+pop same edge -> new
//    entry replaces old, count stays 1.
//  - SKID=1: main slot (drives outputs) + skid slot; in_ready is a flop = ~skid_full.
//      count0: push -> main; count1: push&pop -> main<=in; push&~pop -> skid<=in, count2, in_ready->0;
//      pop&~push -> count0.  count2: no push possible; pop -> main<=skid, count1, in_ready->1.
//  - Upstream must not drop in_valid/change in_data while in_valid & ~in_ready (bench asserts this).
//  - Width rules: no arithmetic; payloads copied bit-exact; count never exceeds depth (2 or 1).
// STRUCTURE
//  - Shared include pipe_defs.vh: CTRL bit-index localparams (CTRL_REG_WE=0, CTRL_MEM_WE=1,
//    CTRL_MEM2REG=2, CTRL_IS_JUMP=3), per-stage DATA_W/CTRL_W constants.
//  - Sub-module pipe_skid_buffer (2-slot storage + count FSM), instantiated via generate when SKID=1;
//    SKID=0 path is a single inline register.
//  - Top handles flush/reset priority and out_ctrl bubble masking.
// TESTING (run each for SKID=0 and SKID=1, DATA_W=64, CTRL_W=8)
//  1 reset 3 cycles, in_valid=1 data=0xA5 -> out_valid/out_ctrl/count all 0 during reset; entry out 1 cycle after release.
//  2 stream 0x1..0x20 with out_ready=1 -> one entry out per cycle, in order, 1-cycle latency, in_ready stays 1.
//  3 SKID=1: push 0x11,0x22 with out_ready=0 -> count=2, in_ready=0, out_data=0x11 held; out_ready=1 -> 0x11 then 0x22.
//  4 count=2, flush & in_valid=1 data=0x33 -> next cycle count=0, out_valid=0, out_ctrl=0, 0x33 never appears.
//  5 in_ctrl=0xFF with in_valid=0 for 5 cycles -> out_ctrl stays 0x00, out_valid 0.
//  6 random in_valid/out_ready 10k cycles vs scoreboard queue -> zero mismatch, stability assertion never fires.

Source files
------------

// File: rtl/pipe_stage_regs_pkg.sv
// Shared definitions for the datapath pipeline-stage registers:
// control-word bit positions, per-stage payload widths and skid FSM states.
package pipe_stage_regs_pkg;

    // Control word bit positions
    localparam int unsigned CTRL_REG_WE  = 0;
    localparam int unsigned CTRL_MEM_WE  = 1;
    localparam int unsigned CTRL_MEM2REG = 2;
    localparam int unsigned CTRL_IS_JUMP = 3;

    // Per-stage payload widths
    localparam int unsigned IF_ID_DATA_W  = 64;
    localparam int unsigned IF_ID_CTRL_W  = 8;
    localparam int unsigned ID_EX_DATA_W  = 64;
    localparam int unsigned ID_EX_CTRL_W  = 8;
    localparam int unsigned EX_MEM_DATA_W = 64;
    localparam int unsigned EX_MEM_CTRL_W = 8;
    localparam int unsigned MEM_WB_DATA_W = 64;
    localparam int unsigned MEM_WB_CTRL_W = 8;

    // Occupancy of the 2-entry skid buffer
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/pipe_stage_regs_skid_buffer.sv
// Two-slot skid buffer: the main slot drives the outputs, the skid slot
// catches the one entry accepted while downstream stalls, so in_ready can
// come straight from a flop.
module pipe_skid_buffer
    import pipe_stage_regs_pkg::*;
#(
    parameter int unsigned W = 72
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_payload,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_payload,
    output logic [1:0]   count
);

    skid_state_t  state, state_next;
    logic [W-1:0] main_q, skid_q;
    logic         ready_q;
    logic         push, pop;
    logic         load_main_in, load_main_skid, load_skid;

    assign push        = in_valid & ready_q;
    assign pop         = out_valid & out_ready;
    assign in_ready    = ready_q;
    assign out_valid   = (state != SKID_EMPTY);
    assign out_payload = main_q;
    assign count       = (state == SKID_FULL) ? 2'd2 :
                         (state == SKID_ONE)  ? 2'd1 : 2'd0;

    // Next-state and slot-load decode; flush discards everything
    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_next = SKID_EMPTY;
        end else begin
            case (state)
                SKID_EMPTY: begin
                    if (push) begin
                        load_main_in = 1'b1;
                        state_next   = SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (push && pop) begin
                        load_main_in = 1'b1;
                    end else if (push) begin
                        load_skid  = 1'b1;
                        state_next = SKID_FULL;
                    end else if (pop) begin
                        state_next = SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (pop) begin
                        load_main_skid = 1'b1;
                        state_next     = SKID_ONE;
                    end
                end
                default: state_next = SKID_EMPTY;
            endcase
        end
    end

    // State, registered in_ready and slot storage; reset zeroes the payload
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= SKID_EMPTY;
            ready_q <= 1'b1;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state   <= state_next;
            ready_q <= (state_next != SKID_FULL);
            if (load_main_in) begin
                main_q <= in_payload;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_payload;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_regs.sv
// Generic pipeline-stage register carrying data and control words between
// CPU stages with valid/ready handshake, flush and bubble-safe control.
module pipe_stage_regs
    import pipe_stage_regs_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned SKID   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        count
);

    localparam int unsigned PW = DATA_W + CTRL_W;

    logic [PW-1:0] in_payload;
    logic [PW-1:0] held_payload;
    logic          held_valid;

    assign in_payload = {in_ctrl, in_data};

    generate
        if (SKID != 0) begin : g_skid
            pipe_skid_buffer #(
                .W (PW)
            ) u_skid (
                .clk         (clk),
                .reset       (reset),
                .flush       (flush),
                .in_valid    (in_valid),
                .in_ready    (in_ready),
                .in_payload  (in_payload),
                .out_valid   (held_valid),
                .out_ready   (out_ready),
                .out_payload (held_payload),
                .count       (count)
            );
        end else begin : g_single
            logic          valid_q;
            logic [PW-1:0] payload_q;

            assign in_ready     = ~valid_q | out_ready;
            assign held_valid   = valid_q;
            assign held_payload = payload_q;
            assign count        = {1'b0, valid_q};

            // Single register: a push replaces the entry even on a coincident pop
            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_q   <= 1'b0;
                    payload_q <= '0;
                end else if (flush) begin
                    valid_q <= 1'b0;
                end else if (in_valid && in_ready) begin
                    valid_q   <= 1'b1;
                    payload_q <= in_payload;
                end else if (valid_q && out_ready) begin
                    valid_q <= 1'b0;
                end
            end
        end
    endgenerate

    // Control is masked during bubbles; data keeps its last value
    always_comb begin
        out_valid = held_valid;
        out_data  = held_payload[DATA_W-1:0];
        out_ctrl  = held_valid ? held_payload[PW-1:DATA_W] : '0;
    end

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Scoreboard bench for pipe_stage_regs: one SKID=0 and one SKID=1 instance,
// exercised in turn with directed and random handshake traffic.
module tb_pipe_stage_regs;

    typedef logic [71:0] ent_t;

    logic        clk = 1'b0;
    logic        reset     [2];
    logic        flush     [2];
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [63:0] in_data   [2];
    logic [7:0]  in_ctrl   [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [63:0] out_data  [2];
    logic [7:0]  out_ctrl  [2];
    logic [1:0]  count     [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_regs #(.DATA_W(64), .CTRL_W(8), .SKID(0)) u_dut_reg (
        .clk(clk), .reset(reset[0]), .flush(flush[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_ctrl(in_ctrl[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .out_ctrl(out_ctrl[0]), .count(count[0])
    );

    pipe_stage_regs #(.DATA_W(64), .CTRL_W(8), .SKID(1)) u_dut_skid (
        .clk(clk), .reset(reset[1]), .flush(flush[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_ctrl(in_ctrl[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .out_ctrl(out_ctrl[1]), .count(count[1])
    );

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Per-instance scoreboard and protocol monitor, sampled on the falling edge
    for (genvar g = 0; g < 2; g++) begin : g_mon
        localparam int DEPTH = g + 1;
        ent_t sb[$];
        logic armed     = 1'b0;
        logic prev_stall = 1'b0;
        logic prev_pend  = 1'b0;
        ent_t prev_out;
        ent_t prev_in;

        always @(negedge clk) begin
            logic exp_ready;
            if (!out_valid[g])
                check($sformatf("d%0d_bubble_ctrl", g), 72'(out_ctrl[g]), 72'd0);
            if (armed) begin
                exp_ready = (sb.size() < DEPTH) || (DEPTH == 1 && out_ready[g]);
                check($sformatf("d%0d_count", g), 72'(count[g]), 72'(sb.size()));
                check($sformatf("d%0d_in_ready", g), 72'(in_ready[g]), 72'(exp_ready));
            end
            if (prev_stall)
                check($sformatf("d%0d_stall_hold", g), {out_ctrl[g], out_data[g]}, prev_out);
            if (prev_pend) begin
                check($sformatf("d%0d_upstream_valid", g), 72'(in_valid[g]), 72'd1);
                check($sformatf("d%0d_upstream_data", g), {in_ctrl[g], in_data[g]}, prev_in);
            end
            if (out_valid[g] && out_ready[g] && !reset[g]) begin
                if (sb.size() == 0)
                    check($sformatf("d%0d_sb_empty", g), 72'd1, 72'd0);
                else
                    check($sformatf("d%0d_sb_data", g), {out_ctrl[g], out_data[g]}, sb.pop_front());
            end
            prev_stall = out_valid[g] && !out_ready[g] && !reset[g] && !flush[g];
            prev_out   = {out_ctrl[g], out_data[g]};
            prev_pend  = in_valid[g] && !in_ready[g] && !reset[g] && !flush[g];
            prev_in    = {in_ctrl[g], in_data[g]};
            if (reset[g] || flush[g]) begin
                sb.delete();
                if (reset[g]) armed = 1'b1;
            end else if (in_valid[g] && in_ready[g]) begin
                sb.push_back({in_ctrl[g], in_data[g]});
            end
        end
    end

    task automatic run_dut(input int d);
        int depth = d + 1;
        logic hold;
        // reset with an entry presented
        reset[d] = 1'b1; flush[d] = 1'b0; out_ready[d] = 1'b0;
        in_valid[d] = 1'b1; in_data[d] = 64'hA5; in_ctrl[d] = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("d%0d_rst_valid", d), 72'(out_valid[d]), 72'd0);
            check($sformatf("d%0d_rst_ctrl", d), 72'(out_ctrl[d]), 72'd0);
            check($sformatf("d%0d_rst_count", d), 72'(count[d]), 72'd0);
        end
        reset[d] = 1'b0; out_ready[d] = 1'b1;
        step();
        in_valid[d] = 1'b0;
        check($sformatf("d%0d_lat_valid", d), 72'(out_valid[d]), 72'd1);
        check($sformatf("d%0d_lat_data", d), 72'(out_data[d]), 72'hA5);
        check($sformatf("d%0d_lat_ctrl", d), 72'(out_ctrl[d]), 72'h5A);
        step();
        check($sformatf("d%0d_drain_valid", d), 72'(out_valid[d]), 72'd0);

        // full-rate stream
        for (int i = 1; i <= 32; i++) begin
            in_valid[d] = 1'b1; in_data[d] = 64'(i); in_ctrl[d] = 8'(i);
            check($sformatf("d%0d_stream_ready", d), 72'(in_ready[d]), 72'd1);
            step();
            check($sformatf("d%0d_stream_valid", d), 72'(out_valid[d]), 72'd1);
            check($sformatf("d%0d_stream_data", d), 72'(out_data[d]), 72'(i));
        end
        in_valid[d] = 1'b0;
        step();

        // fill under stall, then release
        out_ready[d] = 1'b0;
        in_valid[d] = 1'b1; in_data[d] = 64'h11; in_ctrl[d] = 8'h01;
        step();
        if (in_ready[d]) begin
            in_data[d] = 64'h22; in_ctrl[d] = 8'h02;
            step();
        end
        in_valid[d] = 1'b0;
        check($sformatf("d%0d_full_count", d), 72'(count[d]), 72'(depth));
        check($sformatf("d%0d_full_ready", d), 72'(in_ready[d]), 72'd0);
        check($sformatf("d%0d_full_data", d), 72'(out_data[d]), 72'h11);
        step(3);
        check($sformatf("d%0d_held_data", d), 72'(out_data[d]), 72'h11);
        out_ready[d] = 1'b1;
        step();
        if (depth == 2) check($sformatf("d%0d_second_data", d), 72'(out_data[d]), 72'h22);
        step(2);
        check($sformatf("d%0d_empty_count", d), 72'(count[d]), 72'd0);

        // flush with coincident push
        out_ready[d] = 1'b0;
        in_valid[d] = 1'b1; in_data[d] = 64'h44; in_ctrl[d] = 8'h04;
        step();
        if (in_ready[d]) begin
            in_data[d] = 64'h55; in_ctrl[d] = 8'h05;
            step();
        end
        out_ready[d] = 1'b1; flush[d] = 1'b1;
        in_valid[d] = 1'b1; in_data[d] = 64'h33; in_ctrl[d] = 8'hFF;
        step();
        flush[d] = 1'b0; in_valid[d] = 1'b0;
        check($sformatf("d%0d_flush_count", d), 72'(count[d]), 72'd0);
        check($sformatf("d%0d_flush_valid", d), 72'(out_valid[d]), 72'd0);
        check($sformatf("d%0d_flush_ctrl", d), 72'(out_ctrl[d]), 72'd0);
        check($sformatf("d%0d_flush_ready", d), 72'(in_ready[d]), 72'd1);
        check($sformatf("d%0d_flush_data", d), 72'(out_data[d]), 72'h44);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("d%0d_post_flush_valid", d), 72'(out_valid[d]), 72'd0);
        end

        // idle control must not leak
        in_ctrl[d] = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            in_data[d] = {$urandom, $urandom};
            step();
            check($sformatf("d%0d_idle_ctrl", d), 72'(out_ctrl[d]), 72'd0);
            check($sformatf("d%0d_idle_valid", d), 72'(out_valid[d]), 72'd0);
        end

        // random handshake traffic with rare flushes
        hold = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if (!hold) begin
                in_valid[d] = ($urandom_range(0, 2) != 0);
                in_data[d]  = {$urandom, $urandom};
                in_ctrl[d]  = 8'($urandom);
            end
            out_ready[d] = ($urandom_range(0, 2) != 0);
            flush[d]     = ($urandom_range(0, 199) == 0);
            @(negedge clk);
            hold = in_valid[d] && !in_ready[d] && !flush[d];
            @(posedge clk);
            #1;
        end
        in_valid[d] = 1'b0; flush[d] = 1'b0; out_ready[d] = 1'b1;
        step(4);
        check($sformatf("d%0d_final_count", d), 72'(count[d]), 72'd0);
        out_ready[d] = 1'b0;
        reset[d] = 1'b1;
        step();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            reset[i] = 1'b1; flush[i] = 1'b0; in_valid[i] = 1'b0;
            in_data[i] = '0; in_ctrl[i] = '0; out_ready[i] = 1'b0;
        end
        step(2);
        run_dut(0);
        run_dut(1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
